gpio_apb_ctrl: RTL and testbench
================================

Name: gpio_apb_ctrl

Overview:
- APB3 slave front-end that sequences the GPIO register block's single-port register interface (gpio_addr / gpio_dat_i / gpio_we / gpio_dat_o).
- After reset it runs a two-write init sequence that programs RGPIO_OE and RGPIO_CTRL defaults, then accepts APB transfers.
- APB transfers have programmable wait states and slave-error reporting for unmapped or read-only writes.
- Sits between the system APB interconnect and the register block; all register-block accesses go through it.

Parameters:
- WAIT_STATES, 0, ACCESS-phase cycles with pready low before completion; legal range 0..7.
- INIT_OE, 32'h0000_0000, value written to RGPIO_OE during the init sequence.
- INIT_CTRL, 32'h0000_0000, value written to RGPIO_CTRL during the init sequence (only bits [1:0] are meaningful).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  32  APB address; byte offsets per the gpio_defines.sv GPIO_RGPIO_* map.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  APB transfer complete.
- pslverr  out  1  APB slave error; valid only with pready.
- gpio_addr  out  32  register-block address.
- gpio_dat_i  out  32  register-block write data.
- gpio_we  out  1  register-block write strobe; one cycle per write.
- gpio_dat_o  in  32  register-block read data; combinational from gpio_addr.
- init_done  out  1  high once the init sequence has finished.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state = INIT_OE.
  - prdata, pready, pslverr, gpio_we, init_done, gpio_addr, gpio_dat_i, wait counter and latched request all = 0.
  - An in-flight transfer is dropped without a register write.
- State INIT_OE (1 cycle): gpio_addr = GPIO_RGPIO_OE, gpio_dat_i = INIT_OE, gpio_we = 1; next state INIT_CTRL.
- State INIT_CTRL (1 cycle): gpio_addr = GPIO_RGPIO_CTRL, gpio_dat_i = INIT_CTRL, gpio_we = 1; next state IDLE.
- init_done is registered and reads 1 from the first IDLE cycle until reset.
- During INIT states APB is ignored: pready = 0, and a setup presented then is not captured.
- State IDLE:
  - Outputs gpio_we = 0, pready = 0; gpio_addr and gpio_dat_i hold their previous values.
  - On psel=1 & penable=0: latch paddr, pwrite, pwdata; load wait counter = WAIT_STATES; compute err; go to ACCESS.
  - err = paddr matches no GPIO_RGPIO_* define, OR (pwrite=1 AND paddr = GPIO_RGPIO_IN).
  - psel=1 & penable=1 seen in IDLE (protocol violation) is ignored.
- State ACCESS:
  - gpio_addr = latched address; gpio_dat_i = latched wdata.
  - Counter != 0: pready = 0, counter decrements.
  - Counter == 0: pready = 1 for exactly one cycle.
  - At pready:
    - gpio_we = latched write & !err.
    - prdata = gpio_dat_o if read & !err, else 0.
    - pslverr = err.
    - Next state IDLE.
  - If psel drops before pready: abort to IDLE; no gpio_we, pready stays 0.
- Latency: completion cycle = setup cycle + 1 + WAIT_STATES. WAIT_STATES=0 gives the 2-cycle APB minimum.
- Back-to-back: a new setup phase is accepted in the IDLE cycle right after completion, so one idle bubble is inherent to APB.
- prdata, pslverr and gpio_we are 0 on every cycle where pready = 0.
- The register-block write occurs on the same rising edge that ends the APB access. A read in the next transfer therefore returns the new value.

Test Plan:
- Release reset, INIT_OE=32'hFFFF_0000, INIT_CTRL=32'h1 -> two gpio_we pulses on cycles 1 and 2 (OE then CTRL); init_done=1 from cycle 3; APB read of RGPIO_OE returns 32'hFFFF_0000.
- WAIT_STATES=0: write RGPIO_OUT=32'h1234_5678, then read it -> write pready on the cycle after setup with exactly one gpio_we; read prdata=32'h1234_5678, pslverr=0.
- WAIT_STATES=3: read RGPIO_OE -> pready low for 3 ACCESS cycles, high on the 4th; prdata valid only then.
- Write 32'hDEAD_BEEF to RGPIO_IN, then read unmapped 32'h0000_0FFC -> both complete with pslverr=1; no gpio_we; prdata=0.
- Setup issued while init_done=0 -> ignored, pready never asserts. Setup during ACCESS with psel dropped mid-wait (WAIT_STATES=2) -> abort with no write; a subsequent read of RGPIO_OUT returns the old value.
- Assert sys_rst during ACCESS of a write to RGPIO_INTE -> all outputs 0 immediately; no gpio_we; the init sequence reruns after release.

Source files
------------

// File: rtl/gpio_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_apb_ctrl_if
// APB3 bus bundle between the system interconnect (master) and the GPIO
// APB front-end (slave).
//   psel, penable, pwrite : transfer control, driven by the master
//   paddr, pwdata         : byte address and write data, driven by the master
//   prdata                : read data, driven by the slave
//   pready, pslverr       : completion and error, driven by the slave
// ---------------------------------------------------------------------------
interface gpio_apb_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_apb_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_apb_ctrl
// APB3 slave front-end for the GPIO register block. After reset it writes
// the RGPIO_OE and RGPIO_CTRL defaults, then turns APB transfers into
// single-cycle register-block accesses with WAIT_STATES extra ACCESS cycles.
// Ports:
//   sys_clk, sys_rst : clock (rising edge) and asynchronous active-high reset
//   apb              : APB3 slave bundle (psel/penable/pwrite/paddr/pwdata in,
//                      prdata/pready/pslverr out)
//   gpio_addr        : register-block byte address
//   gpio_dat_i       : register-block write data
//   gpio_we          : register-block write strobe, one cycle per write
//   gpio_dat_o       : register-block read data (combinational from gpio_addr)
//   init_done        : high once the init writes have been issued
// ---------------------------------------------------------------------------
module gpio_apb_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] INIT_OE     = 32'h0000_0000,
  parameter logic [31:0] INIT_CTRL   = 32'h0000_0000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  gpio_apb_ctrl_if.slave        apb,
  output logic [31:0]           gpio_addr,
  output logic [31:0]           gpio_dat_i,
  output logic                  gpio_we,
  input  logic [31:0]           gpio_dat_o,
  output logic                  init_done
);

  // Register byte offsets of the GPIO register block.
  localparam logic [31:0] GPIO_RGPIO_IN    = 32'h00;
  localparam logic [31:0] GPIO_RGPIO_OUT   = 32'h04;
  localparam logic [31:0] GPIO_RGPIO_OE    = 32'h08;
  localparam logic [31:0] GPIO_RGPIO_INTE  = 32'h0C;
  localparam logic [31:0] GPIO_RGPIO_PTRIG = 32'h10;
  localparam logic [31:0] GPIO_RGPIO_AUX   = 32'h14;
  localparam logic [31:0] GPIO_RGPIO_CTRL  = 32'h18;
  localparam logic [31:0] GPIO_RGPIO_INTS  = 32'h1C;
  localparam logic [31:0] GPIO_RGPIO_ECLK  = 32'h20;
  localparam logic [31:0] GPIO_RGPIO_NEC   = 32'h24;

  localparam logic [2:0] WS = WAIT_STATES[2:0];

  typedef enum logic [1:0] {
    ST_INIT_OE,
    ST_INIT_CTRL,
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        wr_reg, wr_next;
  logic        err_reg, err_next;
  logic        pready_reg, pready_next;
  logic        pslverr_reg, pslverr_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] dat_reg, dat_next;
  logic        init_done_reg, init_done_next;
  logic        mapped;
  logic        setup_err;

  always_comb begin
    mapped = 1'b0;
    case (apb.paddr)
      GPIO_RGPIO_IN, GPIO_RGPIO_OUT, GPIO_RGPIO_OE, GPIO_RGPIO_INTE,
      GPIO_RGPIO_PTRIG, GPIO_RGPIO_AUX, GPIO_RGPIO_CTRL, GPIO_RGPIO_INTS,
      GPIO_RGPIO_ECLK, GPIO_RGPIO_NEC: mapped = 1'b1;
      default:                         mapped = 1'b0;
    endcase
  end

  // RGPIO_IN reflects pin state and cannot be written.
  assign setup_err = !mapped || (apb.pwrite && (apb.paddr == GPIO_RGPIO_IN));

  // Outputs are registered: the values computed here appear in the cycle
  // after the current state, so each init write is visible for one cycle
  // and lands in the register block on the edge that ends it.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    wr_next        = wr_reg;
    err_next       = err_reg;
    addr_next      = addr_reg;
    dat_next       = dat_reg;
    init_done_next = init_done_reg;
    pready_next    = 1'b0;
    pslverr_next   = 1'b0;
    we_next        = 1'b0;
    case (state_reg)
      ST_INIT_OE: begin
        addr_next  = GPIO_RGPIO_OE;
        dat_next   = INIT_OE;
        we_next    = 1'b1;
        state_next = ST_INIT_CTRL;
      end
      ST_INIT_CTRL: begin
        addr_next  = GPIO_RGPIO_CTRL;
        dat_next   = INIT_CTRL;
        we_next    = 1'b1;
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        init_done_next = 1'b1;
        // The first IDLE cycle still shows the CTRL write, so setups are
        // only taken once init_done is visible.
        if (init_done_reg && apb.psel && !apb.penable) begin
          addr_next  = apb.paddr;
          dat_next   = apb.pwdata;
          wr_next    = apb.pwrite;
          err_next   = setup_err;
          cnt_next   = WS;
          state_next = ST_ACCESS;
          if (WS == 3'd0) begin
            pready_next  = 1'b1;
            we_next      = apb.pwrite && !setup_err;
            pslverr_next = setup_err;
          end
        end
      end
      ST_ACCESS: begin
        if (pready_reg) begin
          state_next = ST_IDLE;
        end else if (!apb.psel) begin
          // Master abandoned the transfer: drop it without a write.
          cnt_next   = 3'd0;
          state_next = ST_IDLE;
        end else if (cnt_reg <= 3'd1) begin
          cnt_next     = 3'd0;
          pready_next  = 1'b1;
          we_next      = wr_reg && !err_reg;
          pslverr_next = err_reg;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: state_next = ST_INIT_OE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= ST_INIT_OE;
      cnt_reg       <= 3'd0;
      wr_reg        <= 1'b0;
      err_reg       <= 1'b0;
      pready_reg    <= 1'b0;
      pslverr_reg   <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'h0;
      dat_reg       <= 32'h0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wr_reg        <= wr_next;
      err_reg       <= err_next;
      pready_reg    <= pready_next;
      pslverr_reg   <= pslverr_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      dat_reg       <= dat_next;
      init_done_reg <= init_done_next;
    end
  end

  // Read data comes straight from the register block while gpio_addr holds
  // the latched address, so it is only passed through in the pready cycle.
  assign apb.prdata  = (pready_reg && !wr_reg && !err_reg) ? gpio_dat_o : 32'h0;
  assign apb.pready  = pready_reg;
  assign apb.pslverr = pslverr_reg;
  assign gpio_addr   = addr_reg;
  assign gpio_dat_i  = dat_reg;
  assign gpio_we     = we_reg;
  assign init_done   = init_done_reg;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
module tb_gpio_apb_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = 32'h0;
  logic [31:0] pwdata  = 32'h0;
  int          cur     = 0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  logic [31:0] prdata_w    [3];
  logic        pready_w    [3];
  logic        pslverr_w   [3];
  logic [31:0] gaddr_w     [3];
  logic [31:0] gdat_w      [3];
  logic        gwe_w       [3];
  logic        init_done_w [3];
  int          we_cnt_w    [3];

  gpio_apb_ctrl_if apb [3] ();

  // Instance 0: WAIT_STATES=0, instance 1: 3, instance 2: 2.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned WS = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
      logic [31:0] gpio_addr, gpio_dat_i, gpio_dat_o;
      logic        gpio_we, init_done;
      logic [31:0] regs [16];
      int          we_cnt;

      initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        we_cnt = 0;
      end

      assign apb[gi].psel    = psel && (cur == gi);
      assign apb[gi].penable = penable;
      assign apb[gi].pwrite  = pwrite;
      assign apb[gi].paddr   = paddr;
      assign apb[gi].pwdata  = pwdata;

      gpio_apb_ctrl #(
        .WAIT_STATES(WS),
        .INIT_OE    (32'hFFFF_0000),
        .INIT_CTRL  (32'h0000_0001)
      ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .apb       (apb[gi]),
        .gpio_addr (gpio_addr),
        .gpio_dat_i(gpio_dat_i),
        .gpio_we   (gpio_we),
        .gpio_dat_o(gpio_dat_o),
        .init_done (init_done)
      );

      // Register-block model: combinational read, write on the clock edge.
      assign gpio_dat_o = (gpio_addr <= 32'h24 && gpio_addr[1:0] == 2'b00) ?
                          regs[gpio_addr[5:2]] : 32'hA5A5_A5A5;
      always @(posedge sys_clk) begin
        if (gpio_we) begin
          regs[gpio_addr[5:2]] <= gpio_dat_i;
          we_cnt <= we_cnt + 1;
        end
      end

      assign prdata_w[gi]    = apb[gi].prdata;
      assign pready_w[gi]    = apb[gi].pready;
      assign pslverr_w[gi]   = apb[gi].pslverr;
      assign gaddr_w[gi]     = gpio_addr;
      assign gdat_w[gi]      = gpio_dat_i;
      assign gwe_w[gi]       = gpio_we;
      assign init_done_w[gi] = init_done;
      assign we_cnt_w[gi]    = we_cnt;
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One APB transfer on instance cur; returns read data, error and the
  // number of cycles from the setup cycle to the pready cycle.
  task automatic apb_do(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int lat);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    lat = 1;
    while (!pready_w[cur] && lat < 16) begin
      chk("wait_prdata", prdata_w[cur], 32'h0);
      chk("wait_gpio_we", {31'h0, gwe_w[cur]}, 32'h0);
      tick();
      lat++;
    end
    rd  = prdata_w[cur];
    err = pslverr_w[cur];
    tick();
    psel = 1'b0; penable = 1'b0;
    chk("pready_one_cycle", {31'h0, pready_w[cur]}, 32'h0);
    $display("xfer dut%0d addr=%h wr=%0d wdata=%h -> rdata=%h slverr=%0d lat=%0d",
             cur, a, w, d, rd, err, lat);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          we0;

  initial begin
    // Reset state, with a setup presented during the init sequence.
    cur = 0;
    tick(); tick();
    chk("rst_pready", {31'h0, pready_w[0]}, 32'h0);
    chk("rst_gpio_we", {31'h0, gwe_w[0]}, 32'h0);
    chk("rst_gpio_addr", gaddr_w[0], 32'h0);
    chk("rst_init_done", {31'h0, init_done_w[0]}, 32'h0);
    sys_rst = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555_5555;
    tick();
    chk("init1_we", {31'h0, gwe_w[0]}, 32'h1);
    chk("init1_addr", gaddr_w[0], 32'h08);
    chk("init1_dat", gdat_w[0], 32'hFFFF_0000);
    chk("init1_done", {31'h0, init_done_w[0]}, 32'h0);
    chk("init1_pready", {31'h0, pready_w[0]}, 32'h0);
    tick();
    chk("init2_we", {31'h0, gwe_w[0]}, 32'h1);
    chk("init2_addr", gaddr_w[0], 32'h18);
    chk("init2_dat", gdat_w[0], 32'h1);
    chk("init2_done", {31'h0, init_done_w[0]}, 32'h0);
    chk("init2_pready", {31'h0, pready_w[0]}, 32'h0);
    tick();
    chk("init3_done", {31'h0, init_done_w[0]}, 32'h1);
    chk("init3_we", {31'h0, gwe_w[0]}, 32'h0);
    chk("init3_addr_not_captured", gaddr_w[0], 32'h18);
    chk("init3_pready", {31'h0, pready_w[0]}, 32'h0);
    penable = 1'b1;
    tick();
    chk("viol_pready", {31'h0, pready_w[0]}, 32'h0);
    chk("viol_addr", gaddr_w[0], 32'h18);
    psel = 1'b0; penable = 1'b0;
    tick();
    chk("init_we_count", we_cnt_w[0], 32'd2);

    // WAIT_STATES=0 transfers.
    apb_do(32'h08, 1'b0, 32'h0, rd, err, lat);
    chk("rd_oe_data", rd, 32'hFFFF_0000);
    chk("rd_oe_lat", lat, 32'd1);
    we0 = we_cnt_w[0];
    apb_do(32'h04, 1'b1, 32'h1234_5678, rd, err, lat);
    chk("wr_out_lat", lat, 32'd1);
    chk("wr_out_err", {31'h0, err}, 32'h0);
    chk("wr_out_prdata", rd, 32'h0);
    chk("wr_out_we_count", we_cnt_w[0] - we0, 32'd1);
    apb_do(32'h04, 1'b0, 32'h0, rd, err, lat);
    chk("rd_out_data", rd, 32'h1234_5678);
    chk("rd_out_err", {31'h0, err}, 32'h0);
    chk("rd_out_lat", lat, 32'd1);

    // Slave errors: write to read-only RGPIO_IN, read of unmapped address.
    we0 = we_cnt_w[0];
    apb_do(32'h00, 1'b1, 32'hDEAD_BEEF, rd, err, lat);
    chk("wr_in_err", {31'h0, err}, 32'h1);
    chk("wr_in_lat", lat, 32'd1);
    apb_do(32'h0000_0FFC, 1'b0, 32'h0, rd, err, lat);
    chk("rd_unmapped_err", {31'h0, err}, 32'h1);
    chk("rd_unmapped_prdata", rd, 32'h0);
    chk("err_no_we", we_cnt_w[0] - we0, 32'd0);

    // WAIT_STATES=3 read.
    cur = 1;
    apb_do(32'h08, 1'b0, 32'h0, rd, err, lat);
    chk("ws3_rd_lat", lat, 32'd4);
    chk("ws3_rd_data", rd, 32'hFFFF_0000);
    chk("ws3_rd_err", {31'h0, err}, 32'h0);

    // WAIT_STATES=2: write, aborted write, read back the old value.
    cur = 2;
    apb_do(32'h04, 1'b1, 32'h1111_2222, rd, err, lat);
    chk("ws2_wr_lat", lat, 32'd3);
    we0 = we_cnt_w[2];
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hCAFE_F00D;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    chk("abort_pready_a", {31'h0, pready_w[2]}, 32'h0);
    tick();
    chk("abort_pready_b", {31'h0, pready_w[2]}, 32'h0);
    tick();
    chk("abort_pready_c", {31'h0, pready_w[2]}, 32'h0);
    chk("abort_no_we", we_cnt_w[2] - we0, 32'd0);
    $display("xfer dut2 addr=00000004 wr=1 wdata=cafef00d -> aborted");
    apb_do(32'h04, 1'b0, 32'h0, rd, err, lat);
    chk("abort_rd_old", rd, 32'h1111_2222);
    chk("abort_rd_lat", lat, 32'd3);

    // Asynchronous reset in the middle of a write to RGPIO_INTE (WS=3).
    cur = 1;
    we0 = we_cnt_w[1];
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h0000_00FF;
    tick();
    penable = 1'b1;
    tick();
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_pready", {31'h0, pready_w[1]}, 32'h0);
    chk("arst_gpio_we", {31'h0, gwe_w[1]}, 32'h0);
    chk("arst_gpio_addr", gaddr_w[1], 32'h0);
    chk("arst_gpio_dat", gdat_w[1], 32'h0);
    chk("arst_init_done", {31'h0, init_done_w[1]}, 32'h0);
    chk("arst_pslverr", {31'h0, pslverr_w[1]}, 32'h0);
    chk("arst_prdata", prdata_w[1], 32'h0);
    $display("xfer dut1 addr=0000000c wr=1 wdata=000000ff -> reset mid-access");
    psel = 1'b0; penable = 1'b0;
    tick();
    sys_rst = 1'b0;
    chk("arst_no_we", we_cnt_w[1] - we0, 32'd0);
    tick();
    chk("rerun1_we", {31'h0, gwe_w[1]}, 32'h1);
    chk("rerun1_addr", gaddr_w[1], 32'h08);
    tick();
    chk("rerun2_addr", gaddr_w[1], 32'h18);
    tick();
    chk("rerun_done", {31'h0, init_done_w[1]}, 32'h1);
    chk("rerun_we_count", we_cnt_w[1] - we0, 32'd2);
    apb_do(32'h0C, 1'b0, 32'h0, rd, err, lat);
    chk("inte_unwritten", rd, 32'h0);
    chk("inte_lat", lat, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
